// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared control-path types and default sizing for the sequencer and decoders.
package ctrl_pkg;
    typedef enum logic {RUN = 1'b0, HALT = 1'b1} mode_e;
    localparam int STATE_WIDTH_DEF = 3;
    localparam int WAIT_LIMIT_DEF  = 15;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts consecutive stalled cycles; hit flags the stall cycle that reaches LIMIT.
module mem_wait_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] cnt_q, cnt_d;
    assign hit = en && (cnt_q == W'(LIMIT - 1));
    always_comb cnt_d = (clr || hit) ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multicycle step sequencer with bounded memory stalls, halt mode and overrun trap.
// Defining CTRL_SINGLE_STEP_EN adds stepMode/stepGo single-step debug control.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int STATE_WIDTH = STATE_WIDTH_DEF,
    parameter int WAIT_LIMIT  = WAIT_LIMIT_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   lastStep,
    input  logic                   memReq,
    input  logic                   memReady,
    input  logic                   haltReq,
    input  logic                   resume,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic                   stepMode,
    input  logic                   stepGo,
`endif
    output logic [STATE_WIDTH-1:0] state,
    output logic                   stepValid,
    output logic                   halted,
    output logic                   retire,
    output logic                   illegalStep,
    output logic                   busError
);
    localparam logic [STATE_WIDTH-1:0] MAX_STEP = '1;
    logic [STATE_WIDTH-1:0] state_q;
    mode_e mode_q;
    logic retire_q, illegal_q, bus_q;
    logic stall, timeout, halt_on_retire, go;
`ifdef CTRL_SINGLE_STEP_EN
    assign halt_on_retire = haltReq | stepMode;
    assign go             = resume | stepGo;
`else
    assign halt_on_retire = haltReq;
    assign go             = resume;
`endif
    assign stepValid   = (mode_q == RUN) & (!memReq | memReady);
    assign stall       = (mode_q == RUN) & !stepValid;
    assign state       = state_q;
    assign halted      = (mode_q == HALT);
    assign retire      = retire_q;
    assign illegalStep = illegal_q;
    assign busError    = bus_q;
    generate
        if (WAIT_LIMIT != 0) begin : g_timer
            mem_wait_timer #(.LIMIT(WAIT_LIMIT)) u_timer (
                .clk(clk), .rst(reset), .clr(!stall), .en(stall), .hit(timeout)
            );
        end else begin : g_no_timer
            assign timeout = 1'b0;
        end
    endgenerate
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q   <= '0;
            mode_q    <= RUN;
            retire_q  <= 1'b0;
            illegal_q <= 1'b0;
            bus_q     <= 1'b0;
        end else begin
            retire_q  <= 1'b0;
            illegal_q <= 1'b0;
            bus_q     <= 1'b0;
            if (mode_q == HALT) begin
                state_q <= '0;
                if (go) mode_q <= RUN;
            end else if (stepValid) begin
                if (lastStep) begin
                    state_q  <= '0;
                    retire_q <= 1'b1;
                    if (halt_on_retire) mode_q <= HALT;
                end else if (state_q == MAX_STEP) begin
                    state_q   <= '0;
                    illegal_q <= 1'b1;
                end else begin
                    state_q <= state_q + 1'b1;
                end
            end else if (timeout) begin
                // abandon the instruction; fetch restarts at step 0
                state_q <= '0;
                bus_q   <= 1'b1;
            end
        end
endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Parametrised step sequencer for the multicycle CPU control path. It generates the step number that the main and ALU decoders consume, and stalls on memory handshakes with a bounded wait. It also supports a halted mode and traps illegal step overruns. It supersedes the fixed 3-bit free-running step counter: the decoders stay combinational, and all control-path sequential behaviour lives here.

## Interface
Parameters:
- STATE_WIDTH, 3, width of the step number; maximum step is 2**STATE_WIDTH-1.
- WAIT_LIMIT, 15, maximum consecutive stalled cycles before a bus error; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  reset; asynchronous, active-high.
- lastStep  in  1  decoder flag: the current step is the final step of this instruction.
- memReq  in  1  decoder flag: the current step performs a memory access.
- memReady  in  1  memory handshake: the access completes this cycle.
- haltReq  in  1  decoder flag: halt after this instruction retires.
- resume  in  1  leave the halted mode.
- state  out  STATE_WIDTH  current step number, driven to the decoders.
- stepValid  out  1  combinational qualifier; all decoder write enables are ANDed with it.
- halted  out  1  high while in HALT.
- retire  out  1  one-cycle pulse: an instruction completed.
- illegalStep  out  1  one-cycle pulse: step overrun trapped.
- busError  out  1  one-cycle pulse: memory wait timeout.

## Operation
- Modes: RUN, HALT.
- stepValid = (mode==RUN) & (!memReq | memReady).
- RUN with stepValid high:
  - lastStep=0 and state<max: state increments.
  - lastStep=1: state goes to 0 and retire pulses. If haltReq=1, mode goes to HALT.
  - lastStep=0 and state==max: state goes to 0 and illegalStep pulses; no retire.
- RUN with stepValid low (stall):
  - state holds and waitCount increments.
  - If WAIT_LIMIT≠0 and waitCount==WAIT_LIMIT-1: the instruction aborts. state goes to 0, waitCount to 0, busError pulses.
- waitCount clears on any cycle with stepValid high. Its width is $clog2(WAIT_LIMIT+1).
- HALT:
  - state stays 0, stepValid is 0, and waitCount holds at 0.
  - resume=1 returns the mode to RUN on the next cycle.
- resume is ignored outside HALT. haltReq is ignored unless lastStep and stepValid are both high.

## Timing
- Reset values: state=0, mode=RUN, halted=0, retire=0, illegalStep=0, busError=0, waitCount=0.
- Reset is asynchronous and takes effect mid-instruction. After reset, fetch restarts at step 0.
- Step latency is one cycle per valid step. A memory step with memReady already high costs no extra cycles.
- retire, illegalStep and busError are registered. Each is high for exactly the one cycle after the qualifying edge, coincident with state=0.
- halted is registered and rises in the same cycle that state becomes 0 after a halting retire.
- stepValid is the only combinational output. Its path is memReady → stepValid, with no register.
- Timeout: a stall with memReady held low for WAIT_LIMIT cycles ends with busError on the following cycle.

## Configuration
- CTRL_SINGLE_STEP_EN defined:
  - Adds input ports stepMode (1 bit) and stepGo (1 bit).
  - While stepMode=1, every retire enters HALT as if haltReq were set.
  - In HALT, stepGo=1 acts as resume.
  - If stepMode falls while halted, the block stays halted until resume or stepGo.
- CTRL_SINGLE_STEP_EN undefined: the ports are absent, and only haltReq and resume control HALT.

## Structure
- Shared package ctrl_pkg holds:
  - the mode enum (RUN=1'b0, HALT=1'b1);
  - the default STATE_WIDTH constant, shared with the decoders;
  - the default WAIT_LIMIT constant.
- One sub-module, mem_wait_timer: a stall counter with clear, enable and limit-hit output, generated only when WAIT_LIMIT≠0.
- The step counter and mode FSM stay in ctrl_sequencer.

## Test plan
- Reset mid-instruction at state=2: state=0, all pulses 0 immediately. The first edge after reset release gives state=1.
- A 4-step instruction (lastStep at step 3, memReq=0) gives states 0,1,2,3,0 with retire high only on the second 0.
- Stall: memReq=1 at step 1 with memReady low for 3 cycles gives state=1 held, stepValid=0 for 3 cycles, then state=2 one cycle after memReady.
- Timeout with WAIT_LIMIT=4: memReady held low gives busError in the 5th stalled cycle and state=0. No retire. The next instruction runs normally.
- Overrun with STATE_WIDTH=3 and lastStep never asserted: steps 0..7, then illegalStep pulses with state=0.
- Halt: haltReq with lastStep gives retire, halted=1 and stepValid=0 for 10 cycles. resume gives halted=0 next cycle and step 1 the cycle after. With CTRL_SINGLE_STEP_EN, stepMode=1 halts after every retire and each stepGo runs exactly one instruction.
